// File: rtl/mem_ctrl.sv
// mem_ctrl: sequences a single-port synchronous RAM (one-cycle registered read)
// for single-word and incrementing-burst load/store requests from the CPU.
module mem_ctrl #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [DATA_W-1:0] wdata,
    output logic              wnext,
    output logic              busy,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              done,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_READ     = 2'd1,
        ST_RD_DRAIN = 2'd2,
        ST_WRITE    = 2'd3
    } state_t;

    state_t              r_state;
    logic [LEN_W-1:0]    r_rem;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rdata_valid;
    logic                r_done;
    // RAM sampled a read at the previous edge, so data_out now holds a requested word
    logic                r_ram_vld;

    state_t              w_state_nxt;
    logic [LEN_W-1:0]    w_rem_nxt;
    logic                w_mem_read_nxt;
    logic                w_mem_write_nxt;
    logic [ADDR_W-1:0]   w_mem_addr_nxt;
    logic [DATA_W-1:0]   w_mem_wdata_nxt;
    logic [DATA_W-1:0]   w_rdata_nxt;
    logic                w_rdata_valid_nxt;
    logic                w_done_nxt;
    logic                w_ram_vld_nxt;
    logic                w_rem_nz;

    assign w_rem_nz = (r_rem != LEN_W'(0));

    // Next-state and next-output logic for the access sequencer
    always_comb begin
        w_state_nxt       = r_state;
        w_rem_nxt         = r_rem;
        w_mem_read_nxt    = r_mem_read;
        w_mem_write_nxt   = r_mem_write;
        w_mem_addr_nxt    = r_mem_addr;
        w_mem_wdata_nxt   = r_mem_wdata;
        w_rdata_nxt       = r_rdata;
        w_rdata_valid_nxt = 1'b0;
        w_done_nxt        = 1'b0;
        w_ram_vld_nxt     = r_mem_read;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_mem_addr_nxt = addr_in;
                    w_rem_nxt      = burst_len;
                    if (rw) begin
                        w_mem_write_nxt = 1'b1;
                        w_mem_wdata_nxt = wdata;
                        w_state_nxt     = ST_WRITE;
                    end else begin
                        w_mem_read_nxt = 1'b1;
                        w_state_nxt    = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (r_ram_vld) begin
                    w_rdata_nxt       = mem_rdata;
                    w_rdata_valid_nxt = 1'b1;
                end
                if (w_rem_nz) begin
                    w_mem_addr_nxt = r_mem_addr + ADDR_W'(1);
                    w_rem_nxt      = r_rem - LEN_W'(1);
                end else begin
                    w_mem_read_nxt = 1'b0;
                    w_state_nxt    = ST_RD_DRAIN;
                end
            end
            ST_RD_DRAIN: begin
                w_rdata_nxt       = mem_rdata;
                w_rdata_valid_nxt = 1'b1;
                w_done_nxt        = 1'b1;
                w_state_nxt       = ST_IDLE;
            end
            ST_WRITE: begin
                if (w_rem_nz) begin
                    w_mem_addr_nxt  = r_mem_addr + ADDR_W'(1);
                    w_mem_wdata_nxt = wdata;
                    w_rem_nxt       = r_rem - LEN_W'(1);
                end else begin
                    w_mem_write_nxt = 1'b0;
                    w_done_nxt      = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_mem_read_nxt  = 1'b0;
                w_mem_write_nxt = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any burst immediately
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state       <= ST_IDLE;
            r_rem         <= '0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_done        <= 1'b0;
            r_ram_vld     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rem         <= w_rem_nxt;
            r_mem_read    <= w_mem_read_nxt;
            r_mem_write   <= w_mem_write_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_mem_wdata   <= w_mem_wdata_nxt;
            r_rdata       <= w_rdata_nxt;
            r_rdata_valid <= w_rdata_valid_nxt;
            r_done        <= w_done_nxt;
            r_ram_vld     <= w_ram_vld_nxt;
        end
    end

    // Write burst asks for the next word while words remain
    assign wnext       = (r_state == ST_WRITE) && w_rem_nz;
    assign busy        = (r_state != ST_IDLE);
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign done        = r_done;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a behavioural single-port RAM.
module tb_mem_ctrl;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 3;

    logic              clk;
    logic              clr;
    logic              start;
    logic              rw;
    logic [ADDR_W-1:0] addr_in;
    logic [LEN_W-1:0]  burst_len;
    logic [DATA_W-1:0] wdata;
    logic              wnext;
    logic              busy;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              done;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Bench-side RAM preload port
    logic              pl_we;
    logic [ADDR_W-1:0] pl_a;
    logic [DATA_W-1:0] pl_d;

    logic [DATA_W-1:0] ram [512];

    int n_vec;
    int n_miss;
    int n_overlap;
    int n_done;
    int n_wnext;

    logic [31:0] e_addr [5];
    logic [31:0] e_rd   [5];
    logic [31:0] e_vld  [5];
    logic [31:0] e_dat  [5];
    logic [31:0] e_done [5];

    mem_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .rw          (rw),
        .addr_in     (addr_in),
        .burst_len   (burst_len),
        .wdata       (wdata),
        .wnext       (wnext),
        .busy        (busy),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .done        (done),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM with one-cycle registered read
    always @(posedge clk) begin
        if (pl_we)
            ram[pl_a] <= pl_d;
        else if (mem_write)
            ram[mem_addr] <= mem_wdata;
        if (mem_read)
            mem_rdata <= ram[mem_addr];
    end

    // Read and write strobes must never overlap
    always @(negedge clk) begin
        if (mem_read && mem_write)
            n_overlap <= n_overlap + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        pl_we = 1'b1;
        pl_a  = a;
        pl_d  = d;
        tick();
        pl_we = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_miss = 0; n_overlap = 0; n_done = 0; n_wnext = 0;
        clr = 1'b0; start = 1'b0; rw = 1'b0; addr_in = '0; burst_len = '0; wdata = '0;
        pl_we = 1'b0; pl_a = '0; pl_d = '0;
        #1 clr = 1'b1;

        preload(9'd5,   32'hDEADBEEF);
        preload(9'd510, 32'hA0A0A0A0);
        preload(9'd511, 32'hB1B1B1B1);
        preload(9'd0,   32'hC2C2C2C2);
        preload(9'd1,   32'hD3D3D3D3);

        // Reset state
        check("rst_busy",  32'(busy), 0);
        check("rst_mrd",   32'(mem_read), 0);
        check("rst_mwr",   32'(mem_write), 0);
        check("rst_maddr", 32'(mem_addr), 0);
        check("rst_mwdat", mem_wdata, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rvld",  32'(rdata_valid), 0);
        check("rst_done",  32'(done), 0);
        check("rst_wnext", 32'(wnext), 0);
        clr = 1'b0;
        tick();

        // Single read of RAM[5]
        start = 1'b1; rw = 1'b0; addr_in = 9'd5; burst_len = 3'd0;
        tick();
        start = 1'b0;
        check("sr_mrd0",  32'(mem_read), 1);
        check("sr_addr0", 32'(mem_addr), 5);
        check("sr_busy0", 32'(busy), 1);
        tick();
        check("sr_mrd1",  32'(mem_read), 0);
        check("sr_vld1",  32'(rdata_valid), 0);
        check("sr_done1", 32'(done), 0);
        tick();
        check("sr_rdata", rdata, 32'hDEADBEEF);
        check("sr_vld2",  32'(rdata_valid), 1);
        check("sr_done2", 32'(done), 1);
        check("sr_busy2", 32'(busy), 0);
        tick();

        // Wrapping 4-word read from 510, with two ignored starts mid-burst
        start = 1'b1; rw = 1'b0; addr_in = 9'd510; burst_len = 3'd3;
        tick();
        check("wr_addr_acc", 32'(mem_addr), 510);
        check("wr_mrd_acc",  32'(mem_read), 1);
        e_addr = '{511, 0, 1, 1, 1};
        e_rd   = '{1, 1, 1, 0, 0};
        e_vld  = '{0, 1, 1, 1, 1};
        e_dat  = '{0, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
        e_done = '{0, 0, 0, 0, 1};
        n_done = 0;
        for (int t = 0; t < 5; t++) begin
            if (t < 2) begin
                start = 1'b1; rw = 1'b1; addr_in = ADDR_W'(100 + t); burst_len = 3'd5;
            end else begin
                start = 1'b0;
            end
            tick();
            check($sformatf("wr_addr%0d", t), 32'(mem_addr), e_addr[t]);
            check($sformatf("wr_mrd%0d", t),  32'(mem_read), e_rd[t]);
            check($sformatf("wr_vld%0d", t),  32'(rdata_valid), e_vld[t]);
            if (e_vld[t] != 0)
                check($sformatf("wr_dat%0d", t), rdata, e_dat[t]);
            check($sformatf("wr_done%0d", t), 32'(done), e_done[t]);
            if (done) n_done++;
        end
        for (int t = 0; t < 2; t++) begin
            tick();
            if (done) n_done++;
        end
        check("wr_one_done", 32'(n_done), 1);
        check("wr_idle",     32'(busy), 0);
        check("wr_no_write", 32'(mem_write), 0);

        // Burst write of 4 words at 20
        start = 1'b1; rw = 1'b1; addr_in = 9'd20; burst_len = 3'd3; wdata = 32'h11;
        n_wnext = 0;
        tick();
        start = 1'b0;
        check("bw_mwr0",  32'(mem_write), 1);
        check("bw_addr0", 32'(mem_addr), 20);
        check("bw_dat0",  mem_wdata, 32'h11);
        for (int k = 1; k < 4; k++) begin
            if (wnext) n_wnext++;
            wdata = 32'(k + 1) * 32'h11;
            tick();
            check($sformatf("bw_addr%0d", k), 32'(mem_addr), 32'(20 + k));
            check($sformatf("bw_dat%0d", k),  mem_wdata, 32'(k + 1) * 32'h11);
            check($sformatf("bw_mwr%0d", k),  32'(mem_write), 1);
        end
        if (wnext) n_wnext++;
        check("bw_wnext_cnt", 32'(n_wnext), 3);
        wdata = 32'hFFFFFFFF;
        tick();
        check("bw_mwr_end", 32'(mem_write), 0);
        check("bw_done",    32'(done), 1);
        check("bw_busy",    32'(busy), 0);
        for (int k = 0; k < 4; k++)
            check($sformatf("bw_ram%0d", 20 + k), ram[20 + k], 32'(k + 1) * 32'h11);

        // Readback of 20..23, then a write accepted in the read's done cycle
        tick();
        start = 1'b1; rw = 1'b0; addr_in = 9'd20; burst_len = 3'd3;
        tick();
        start = 1'b0;
        e_addr = '{21, 22, 23, 23, 23};
        e_dat  = '{0, 32'h11, 32'h22, 32'h33, 32'h44};
        for (int t = 0; t < 5; t++) begin
            tick();
            check($sformatf("rb_addr%0d", t), 32'(mem_addr), e_addr[t]);
            check($sformatf("rb_vld%0d", t),  32'(rdata_valid), e_vld[t]);
            if (e_vld[t] != 0)
                check($sformatf("rb_dat%0d", t), rdata, e_dat[t]);
            check($sformatf("rb_done%0d", t), 32'(done), e_done[t]);
        end
        start = 1'b1; rw = 1'b1; addr_in = 9'd7; burst_len = 3'd0; wdata = 32'h5A;
        tick();
        start = 1'b0;
        check("b2b_busy", 32'(busy), 1);
        check("b2b_mwr",  32'(mem_write), 1);
        check("b2b_addr", 32'(mem_addr), 7);
        check("b2b_dat",  mem_wdata, 32'h5A);
        tick();
        check("b2b_done", 32'(done), 1);
        check("b2b_mwr2", 32'(mem_write), 0);
        check("b2b_ram7", ram[7], 32'h5A);
        tick();

        // Reset during an 8-word read
        start = 1'b1; rw = 1'b0; addr_in = 9'd0; burst_len = 3'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("ab_vld_pre", 32'(rdata_valid), 1);
        check("ab_dat_pre", rdata, 32'hC2C2C2C2);
        #2 clr = 1'b1;
        #1;
        check("ab_mrd",  32'(mem_read), 0);
        check("ab_busy", 32'(busy), 0);
        check("ab_vld",  32'(rdata_valid), 0);
        check("ab_done", 32'(done), 0);
        check("ab_addr", 32'(mem_addr), 0);
        tick();
        clr = 1'b0;
        n_done = 0;
        for (int t = 0; t < 3; t++) begin
            tick();
            if (done) n_done++;
        end
        check("ab_no_done", 32'(n_done), 0);
        check("ab_ram7",    ram[7], 32'h5A);

        // Fresh single read after reset
        start = 1'b1; rw = 1'b0; addr_in = 9'd511; burst_len = 3'd0;
        tick();
        start = 1'b0;
        check("pr_addr", 32'(mem_addr), 511);
        tick();
        tick();
        check("pr_vld",   32'(rdata_valid), 1);
        check("pr_done",  32'(done), 1);
        check("pr_rdata", rdata, 32'hB1B1B1B1);
        tick();

        check("rw_excl", 32'(n_overlap), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
